// File: rtl/mini_core_pkg.sv
// Shared definitions for the mini_core_p processor: opcodes, instruction
// field positions and the control FSM state encoding.
package mini_core_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS_HI  = 9;
    localparam int RS_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcodes 2..6 are the ALU operations that update the zero flag.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mini_core_alu.sv
// Combinational ALU for mini_core_p. Unknown opcodes pass operand b through,
// which is how LDI moves its immediate into the result register.
module mini_alu
    import mini_core_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          zero,
    output logic          carry
);

    logic [DW:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            // Bit DW of the extended subtraction is the borrow.
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = {1'b0, b};
        endcase
        result = wide[DW-1:0];
        carry  = wide[DW];
        zero   = (wide[DW-1:0] == '0);
    end

endmodule

// File: rtl/mini_core_p.sv
// Four-register multi-cycle processor: FETCH/DECODE/EXEC/WB per instruction,
// program memory writable only while stopped (IDLE or HALT).
module mini_core_p
    import mini_core_pkg::*;
#(
    parameter int DW     = 8,
    parameter int IDEPTH = 16,
    parameter int AW     = $clog2(IDEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic [AW-1:0] pc_out,
    output logic          busy,
    output logic          halted,
    output logic          zflag,
    output logic          cflag,
    output logic [2:0]    dbg_state
);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] pc;
    logic [15:0]   ir;
    logic [DW-1:0] regs [4];
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] res_q;
    logic [15:0]   imem [IDEPTH];

    logic [3:0]    ir_op;
    logic [1:0]    ir_rd;
    logic [1:0]    ir_rs;
    logic [DW-1:0] imm_ext;
    logic [AW-1:0] jump_target;
    logic          stopped;
    logic          writes_rd;
    logic          jump_taken;

    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          alu_carry;

    assign ir_op       = ir[OP_HI:OP_LO];
    assign ir_rd       = ir[RD_HI:RD_LO];
    assign ir_rs       = ir[RS_HI:RS_LO];
    assign imm_ext     = DW'(ir[IMM_HI:IMM_LO]);
    assign jump_target = ir[AW-1:0];
    assign stopped     = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign writes_rd   = (ir_op == OP_LDI) || is_alu_op(ir_op);
    assign jump_taken  = (ir_op == OP_JMP) || ((ir_op == OP_JZ) && zflag);

    mini_alu #(
        .DW (DW)
    ) u_alu (
        .op     (ir_op),
        .a      (opa),
        .b      (opb),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_HALT:   if (start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = (ir_op == OP_HALT) ? ST_HALT : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            ir    <= '0;
            opa   <= '0;
            opb   <= '0;
            res_q <= '0;
            zflag <= 1'b0;
            cflag <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE,
                ST_HALT: begin
                    if (start) pc <= '0;
                end
                ST_FETCH: begin
                    ir <= imem[pc];
                end
                ST_DECODE: begin
                    opa <= regs[ir_rd];
                    opb <= (ir_op == OP_LDI) ? imm_ext : regs[ir_rs];
                end
                ST_EXEC: begin
                    res_q <= alu_result;
                    if (is_alu_op(ir_op))   zflag <= alu_zero;
                    if (is_arith_op(ir_op)) cflag <= alu_carry;
                end
                ST_WB: begin
                    if (writes_rd) regs[ir_rd] <= res_q;
                    pc <= jump_taken ? jump_target : pc + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // No reset on the program store: its contents must survive rst.
    always_ff @(posedge clk) begin
        if (!rst && prog_we && stopped) begin
            imem[prog_addr] <= prog_data;
        end
    end

    assign dbg_data  = regs[dbg_sel];
    assign pc_out    = pc;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXEC)  || (state_q == ST_WB);
    assign halted    = (state_q == ST_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mini_core_p.sv
// Self-checking bench for mini_core_p: directed program table, multi-cycle
// corner sequences, and random programs against an ISA-level model.
module tb_mini_core_p;
    import mini_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [1:0]  dbg_sel = '0;
    logic [7:0]  dbg_data;
    logic [3:0]  pc_out;
    logic        busy, halted, zflag, cflag;
    logic [2:0]  dbg_state;

    logic        s_start = 1'b0;
    logic        s_prog_we = 1'b0;
    logic [1:0]  s_prog_addr = '0;
    logic [15:0] s_prog_data = '0;
    logic [1:0]  s_dbg_sel = '0;
    logic [7:0]  s_dbg_data;
    logic [1:0]  s_pc;
    logic        s_busy, s_halted, s_z, s_c;
    logic [2:0]  s_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mini_core_p #(.DW(8), .IDEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .pc_out(pc_out), .busy(busy), .halted(halted),
        .zflag(zflag), .cflag(cflag), .dbg_state(dbg_state)
    );

    mini_core_p #(.DW(8), .IDEPTH(4)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .prog_we(s_prog_we),
        .prog_addr(s_prog_addr), .prog_data(s_prog_data), .dbg_sel(s_dbg_sel),
        .dbg_data(s_dbg_data), .pc_out(s_pc), .busy(s_busy), .halted(s_halted),
        .zflag(s_z), .cflag(s_c), .dbg_state(s_state)
    );

    typedef struct packed {
        logic [7:0][15:0] prog;
        logic [7:0]       r0, r1, r2, r3;
        logic             z, c;
        logic [3:0]       pc;
        logic [7:0]       cyc;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] exp_q[$];

    // ISA-level reference state for the random phase
    logic [15:0] m_prog [16];
    int          m_r [4];
    int          m_z, m_c, m_pc, m_k;

    function automatic logic [15:0] ins(input logic [3:0] op, input int rd, input int rs,
                                        input logic [7:0] imm);
        return {op, 2'(rd), 2'(rs), imm};
    endfunction

    function automatic logic [7:0][15:0] p8(input logic [15:0] w0, w1, w2, w3,
                                            input logic [15:0] w4, w5, w6, w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0][15:0] p, input logic [7:0] r0, r1, r2, r3,
                           input logic z, c, input logic [3:0] pc, input logic [7:0] cyc);
        vec_t v;
        v.prog = p; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3;
        v.z = z; v.c = c; v.pc = pc; v.cyc = cyc;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic write_word(input int addr, input logic [15:0] w);
        prog_we = 1'b1; prog_addr = 4'(addr); prog_data = w;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic read_reg(input int i, output logic [7:0] v);
        dbg_sel = 2'(i);
        #1;
        v = dbg_data;
    endtask

    // Pulse start, count cycles until halted. Optional same-cycle write to
    // address 0, and optional meddling (writes and start) while busy.
    task automatic run_prog(input bit wr_first, input logic [15:0] wd, input bit meddle,
                            output int n);
        start = 1'b1;
        if (wr_first) begin
            prog_we = 1'b1; prog_addr = 4'd0; prog_data = wd;
        end
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0;
        n = 1;
        while (!halted && n < 300) begin
            if (meddle) begin
                prog_we   = (n >= 2 && n <= 6);
                prog_addr = 4'd1;
                prog_data = ins(OP_LDI, 1, 0, 8'h55);
                start     = (n == 5);
            end
            @(posedge clk); #1;
            n++;
        end
        prog_we = 1'b0; start = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [7:0] r0, r1, r2, r3,
                               input logic z, c, input logic [3:0] pc,
                               input int cyc, input int n);
        logic [7:0] v;
        read_reg(0, v); chk({tag, " r0"}, 32'(v), 32'(r0));
        read_reg(1, v); chk({tag, " r1"}, 32'(v), 32'(r1));
        read_reg(2, v); chk({tag, " r2"}, 32'(v), 32'(r2));
        read_reg(3, v); chk({tag, " r3"}, 32'(v), 32'(r3));
        chk({tag, " zflag"}, 32'(zflag), 32'(z));
        chk({tag, " cflag"}, 32'(cflag), 32'(c));
        chk({tag, " pc"}, 32'(pc_out), 32'(pc));
        if (cyc >= 0) chk({tag, " cycles"}, 32'(n), 32'(cyc));
    endtask

    task automatic model_run();
        logic [15:0] w;
        logic [3:0]  op;
        int a, b, nxt, done;
        done = 0; m_pc = 0; m_k = 0;
        for (int step = 0; step < 64 && done == 0; step++) begin
            w  = m_prog[m_pc];
            op = w[15:12];
            a  = m_r[w[11:10]];
            b  = m_r[w[9:8]];
            nxt = (m_pc + 1) % 16;
            case (op)
                4'h1: m_r[w[11:10]] = int'(w[7:0]);
                4'h2: begin m_c = (a + b > 255); m_r[w[11:10]] = (a + b) % 256; end
                4'h3: begin m_c = (a < b); m_r[w[11:10]] = (a - b + 256) % 256; end
                4'h4: m_r[w[11:10]] = a & b;
                4'h5: m_r[w[11:10]] = a | b;
                4'h6: m_r[w[11:10]] = a ^ b;
                4'h7: nxt = int'(w[7:0]) % 16;
                4'h8: if (m_z != 0) nxt = int'(w[7:0]) % 16;
                4'hF: done = 1;
                default: ;
            endcase
            if (op >= 4'h2 && op <= 4'h6) m_z = (m_r[w[11:10]] == 0);
            if (done == 0) begin
                m_pc = nxt;
                m_k++;
            end
        end
    endtask

    initial begin
        int n;
        int prev, wrap_seen, halt_seen, step_bad;
        logic [7:0] v;
        vec_t t;
        logic [15:0] h;

        h = ins(OP_HALT, 0, 0, 8'h00);
        add_vec(p8(ins(OP_LDI,0,0,8'h05), ins(OP_LDI,1,0,8'h03), ins(OP_ADD,0,1,8'h00), h, h, h, h, h),
                8'h08, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 4'd3, 8'd16);
        add_vec(p8(ins(OP_LDI,0,0,8'hFF), ins(OP_LDI,1,0,8'h01), ins(OP_ADD,0,1,8'h00), h, h, h, h, h),
                8'h00, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 4'd3, 8'd16);
        add_vec(p8(ins(OP_SUB,2,2,8'h00), ins(OP_JZ,0,0,8'h05), ins(OP_LDI,3,0,8'h01), 16'h0000,
                   16'h0000, h, h, h),
                8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 4'd5, 8'd12);
        add_vec(p8(ins(OP_LDI,1,0,8'h03), ins(OP_LDI,2,0,8'h05), ins(OP_SUB,1,2,8'h00), h, h, h, h, h),
                8'h00, 8'hFE, 8'h05, 8'h00, 1'b0, 1'b1, 4'd3, 8'd16);
        add_vec(p8(ins(OP_LDI,0,0,8'hF0), ins(OP_LDI,1,0,8'h3C), ins(OP_AND,0,1,8'h00),
                   ins(OP_OR,1,0,8'h00), ins(OP_XOR,1,1,8'h00), h, h, h),
                8'h30, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 4'd5, 8'd24);
        add_vec(p8(ins(OP_LDI,3,0,8'h07), ins(OP_JMP,0,0,8'hA4), ins(OP_LDI,3,0,8'h09), h,
                   16'h9FFF, 16'hE123, h, h),
                8'h00, 8'h00, 8'h00, 8'h07, 1'b0, 1'b0, 4'd6, 8'd20);
        add_vec(p8(ins(OP_LDI,0,0,8'h01), ins(OP_LDI,1,0,8'h02), ins(OP_SUB,0,1,8'h00),
                   ins(OP_LDI,2,0,8'h00), ins(OP_JZ,0,0,8'h07), h, h, h),
                8'hFF, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1, 4'd5, 8'd24);
        add_vec(p8(ins(OP_LDI,0,0,8'hFF), ins(OP_LDI,1,0,8'h01), ins(OP_ADD,0,1,8'h00),
                   ins(OP_LDI,0,0,8'h10), ins(OP_JZ,0,0,8'h06), h, h, h),
                8'h10, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 4'd6, 8'd24);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset halted", 32'(halted), 32'd0);
        chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
        check_state("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0, -1, 0);

        // Directed program table
        foreach (vecs[i]) begin
            t = vecs[i];
            do_reset();
            for (int a = 0; a < 8; a++) write_word(a, t.prog[a]);
            run_prog(1'b0, 16'h0000, 1'b0, n);
            chk($sformatf("vec%0d halted", i), 32'(halted), 32'd1);
            check_state($sformatf("vec%0d", i), t.r0, t.r1, t.r2, t.r3, t.z, t.c, t.pc,
                        int'(t.cyc), n);
        end

        // Reset during EXEC of ADD aborts the instruction; program survives
        t = vecs[0];
        do_reset();
        for (int a = 0; a < 8; a++) write_word(a, t.prog[a]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(pc_out == 4'd2 && dbg_state == 3'(ST_EXEC)) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort reach exec", 32'(n < 100), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort state", 32'(dbg_state), 32'(ST_IDLE));
        chk("abort busy", 32'(busy), 32'd0);
        check_state("abort", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0, -1, 0);
        run_prog(1'b0, 16'h0000, 1'b0, n);
        check_state("rerun", 8'h08, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 4'd3, 16, n);

        // Writes and start while busy are ignored
        run_prog(1'b0, 16'h0000, 1'b1, n);
        check_state("busy_we run", 8'h08, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 4'd3, 16, n);
        run_prog(1'b0, 16'h0000, 1'b0, n);
        check_state("busy_we rerun", 8'h08, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 4'd3, 16, n);

        // start and prog_we together in HALT: first FETCH sees the new word
        run_prog(1'b1, ins(OP_LDI, 2, 0, 8'h42), 1'b0, n);
        check_state("start_we", 8'h0B, 8'h03, 8'h42, 8'h00, 1'b0, 1'b0, 4'd3, 16, n);

        // rst outranks start and prog_we
        rst = 1'b1; start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = h;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; prog_we = 1'b0;
        chk("rst_prio state", 32'(dbg_state), 32'(ST_IDLE));
        run_prog(1'b0, 16'h0000, 1'b0, n);
        check_state("rst_prio run", 8'h03, 8'h03, 8'h42, 8'h00, 1'b0, 1'b0, 4'd3, 16, n);

        // IDEPTH=4 instance: pc wraps 3 -> 0 and never halts
        foreach (vecs[i]) if (i < 4) begin
            s_prog_we = 1'b1; s_prog_addr = 2'(i);
            s_prog_data = (i == 0) ? 16'h0000 : (i == 1) ? 16'h0DEF : (i == 2) ? 16'h0123 : 16'h0FFF;
            @(posedge clk); #1;
        end
        s_prog_we = 1'b0;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        prev = int'(s_pc); wrap_seen = 0; halt_seen = 0; step_bad = 0;
        for (int c = 0; c < 48; c++) begin
            @(posedge clk); #1;
            if (s_halted) halt_seen = 1;
            if (int'(s_pc) != prev) begin
                if (int'(s_pc) != (prev + 1) % 4) step_bad = 1;
                if (prev == 3 && s_pc == 2'd0) wrap_seen = 1;
                prev = int'(s_pc);
            end
        end
        chk("wrap seen", 32'(wrap_seen), 32'd1);
        chk("wrap no halt", 32'(halt_seen), 32'd0);
        chk("wrap pc steps", 32'(step_bad), 32'd0);
        chk("wrap busy", 32'(s_busy), 32'd1);
        s_dbg_sel = 2'd3;
        #1;
        chk("wrap r3 untouched", 32'(s_dbg_data), 32'd0);

        // Random programs, forward-only jumps, register state carried across runs
        do_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_z = 0; m_c = 0;
        for (int p = 0; p < 12; p++) begin
            for (int a = 0; a < 16; a++) begin
                logic [3:0] op;
                logic [7:0] imm;
                int tgt;
                op  = 4'($urandom_range(0, 15));
                imm = 8'($urandom_range(0, 255));
                if (op == OP_HALT && $urandom_range(0, 3) != 0) op = OP_LDI;
                if (op == OP_JMP || op == OP_JZ) begin
                    tgt = (a == 15) ? 15 : $urandom_range(a + 1, 15);
                    imm = 8'(($urandom_range(0, 15) << 4) | tgt);
                end
                if (a == 15) op = OP_HALT;
                m_prog[a] = ins(op, $urandom_range(0, 3), $urandom_range(0, 3), imm);
                write_word(a, m_prog[a]);
            end
            model_run();
            for (int i = 0; i < 4; i++) exp_q.push_back(32'(m_r[i]));
            exp_q.push_back(32'(m_z));
            exp_q.push_back(32'(m_c));
            exp_q.push_back(32'(m_pc));
            exp_q.push_back(32'(4 * m_k + 4));
            run_prog(1'b0, 16'h0000, 1'b0, n);
            for (int i = 0; i < 4; i++) begin
                read_reg(i, v);
                chk($sformatf("rand%0d r%0d", p, i), 32'(v), exp_q.pop_front());
            end
            chk($sformatf("rand%0d zflag", p), 32'(zflag), exp_q.pop_front());
            chk($sformatf("rand%0d cflag", p), 32'(cflag), exp_q.pop_front());
            chk($sformatf("rand%0d pc", p), 32'(pc_out), exp_q.pop_front());
            chk($sformatf("rand%0d cycles", p), 32'(n), exp_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
